// File: rtl/dec_pkg.sv
// Shared types for the dec_scan decoder: FSM states, mode encoding and a one-hot helper.
// onehot() is sized by DEC_MAX_W; callers truncate the result to their own output width.
package dec_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_t;

  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_SCAN   = 1'b1
  } mode_t;

  localparam int DEC_MAX_W   = 8;
  localparam int DEC_MAX_OUT = 1 << DEC_MAX_W;

  function automatic logic [DEC_MAX_OUT-1:0] onehot(input logic [DEC_MAX_W-1:0] code);
    logic [DEC_MAX_OUT-1:0] v;
    v       = '0;
    v[code] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/dec_dwell_cnt.sv
// Dwell timer for scan mode: counts cycles spent on the current index.
// done pulses on the last of DWELL cycles; clear has priority over run.
module dec_dwell_cnt #(
  parameter int DWELL = 4,
  parameter int CNT_W = $clog2(DWELL + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic done
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last = (r_cnt == CNT_W'(DWELL - 1));
  assign done   = run & ~clear & w_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (run) begin
      r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/dec_scan.sv
// Registered N-to-2^N one-hot decoder with direct (handshaked code) and scan (self-sequencing) modes.
// Direct and scan-start latency is 1 cycle; in_ready is combinational (en & direct mode).
module dec_scan
  import dec_pkg::*;
#(
  parameter int IN_W  = 3,
  parameter int DWELL = 4,
  parameter int CNT_W = $clog2(DWELL + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 mode,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_W-1:0]      inp,
  output logic [2**IN_W-1:0]   out,
  output logic                 out_valid,
  output logic [IN_W-1:0]      idx,
  output logic                 wrap
);

  localparam int              OUT_W    = 2**IN_W;
  localparam logic [IN_W-1:0] IDX_LAST = '1;

  state_t           r_state, w_state_nxt;
  logic [OUT_W-1:0] r_out, w_out_nxt;
  logic [IN_W-1:0]  r_idx, w_idx_nxt;
  logic             r_wrap, w_wrap_nxt;
  logic             w_cnt_clr, w_cnt_run, w_dwell_done;
  logic             w_accept;
  mode_t            w_mode;

  // IN_W must not exceed DEC_MAX_W for the shared helper to cover every line.
  function automatic logic [OUT_W-1:0] line_sel(input logic [IN_W-1:0] c);
    return OUT_W'(onehot(DEC_MAX_W'(c)));
  endfunction

  assign w_mode   = mode_t'(mode);
  assign in_ready = en & (w_mode == MODE_DIRECT);
  assign w_accept = in_valid & in_ready;

  // Timer only runs while the next cycle stays in SCAN; any other cycle re-arms it.
  assign w_cnt_run = en & (w_mode == MODE_SCAN) & (r_state == SCAN);
  assign w_cnt_clr = ~w_cnt_run;

  dec_dwell_cnt #(
    .DWELL (DWELL),
    .CNT_W (CNT_W)
  ) u_dwell (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (w_cnt_clr),
    .run   (w_cnt_run),
    .done  (w_dwell_done)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_out_nxt   = r_out;
    w_idx_nxt   = r_idx;
    w_wrap_nxt  = 1'b0;
    if (!en) begin
      w_state_nxt = IDLE;
      w_out_nxt   = '0;
      w_idx_nxt   = '0;
    end else if (w_mode == MODE_SCAN) begin
      if (r_state != SCAN) begin
        w_state_nxt = SCAN;
        w_out_nxt   = line_sel('0);
        w_idx_nxt   = '0;
      end else if (w_dwell_done) begin
        w_idx_nxt  = r_idx + IN_W'(1);
        w_out_nxt  = line_sel(r_idx + IN_W'(1));
        w_wrap_nxt = (r_idx == IDX_LAST);
      end
    end else if (w_accept) begin
      // Covers IDLE, DIRECT and the SCAN exit cycle: the code lands without a zero gap.
      w_state_nxt = DIRECT;
      w_out_nxt   = line_sel(inp);
      w_idx_nxt   = inp;
    end else if (r_state == SCAN) begin
      w_state_nxt = IDLE;
      w_out_nxt   = '0;
      w_idx_nxt   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_out   <= '0;
      r_idx   <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_out   <= w_out_nxt;
      r_idx   <= w_idx_nxt;
      r_wrap  <= w_wrap_nxt;
    end
  end

  assign out       = r_out;
  assign idx       = r_idx;
  assign wrap      = r_wrap;
  assign out_valid = (r_state != IDLE);

endmodule

// File: tb/tb_dec_scan.sv
// Scoreboard bench for dec_scan: two instances (IN_W=3/DWELL=4 and IN_W=2/DWELL=1) share stimulus;
// a time-based reference model queues expected outputs and a negedge monitor compares them.
module tb_dec_scan;

  localparam int DW0 = 4;
  localparam int DW1 = 1;
  localparam int N0  = 8;
  localparam int N1  = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       mode = 1'b0;
  logic       in_valid = 1'b0;
  logic [2:0] inp = '0;

  logic       rdy0, rdy1, ov0, ov1, wr0, wr1;
  logic [7:0] out0;
  logic [3:0] out1;
  logic [2:0] idx0;
  logic [1:0] idx1;

  dec_scan #(.IN_W(3), .DWELL(DW0)) u0 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .in_valid(in_valid),
    .in_ready(rdy0), .inp(inp), .out(out0), .out_valid(ov0), .idx(idx0), .wrap(wr0)
  );

  dec_scan #(.IN_W(2), .DWELL(DW1)) u1 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .in_valid(in_valid),
    .in_ready(rdy1), .inp(inp[1:0]), .out(out1), .out_valid(ov1), .idx(idx1), .wrap(wr1)
  );

  always #5 clk = ~clk;

  typedef struct {
    int out;
    int idx;
    int wrap;
    int vld;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Model state per instance: 0 idle, 1 direct, 2 scan; m_t counts cycles since scan entry.
  int m_st[2];
  int m_code[2];
  int m_t[2];

  task automatic check(input string name, input logic [31:0] act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t expect_of(input int k);
    exp_t e;
    int   n;
    int   d;
    int   i;
    n = (k == 0) ? N0 : N1;
    d = (k == 0) ? DW0 : DW1;
    e = '{0, 0, 0, 0};
    if (m_st[k] == 1) begin
      e = '{1 << m_code[k], m_code[k], 0, 1};
    end else if (m_st[k] == 2) begin
      i      = (m_t[k] / d) % n;
      e.out  = 1 << i;
      e.idx  = i;
      e.wrap = (m_t[k] > 0 && (m_t[k] % (d * n)) == 0) ? 1 : 0;
      e.vld  = 1;
    end
    return e;
  endfunction

  task automatic model_step(input bit e_n, input bit md, input bit v, input int code);
    for (int k = 0; k < 2; k++) begin
      if (!e_n) begin
        m_st[k] = 0;
      end else if (md) begin
        if (m_st[k] != 2) begin
          m_st[k] = 2;
          m_t[k]  = 0;
        end else begin
          m_t[k]++;
        end
      end else if (v) begin
        m_st[k]   = 1;
        m_code[k] = (k == 0) ? code % N0 : code % N1;
      end else if (m_st[k] == 2) begin
        m_st[k] = 0;
      end
    end
    q0.push_back(expect_of(0));
    q1.push_back(expect_of(1));
  endtask

  // Called at posedge+1; returns at the following posedge+1.
  task automatic step(input bit e_n, input bit md, input bit v, input int code);
    en       = e_n;
    mode     = md;
    in_valid = v;
    inp      = code[2:0];
    @(negedge clk);
    #1;
    check("in_ready0", rdy0, e_n & ~md);
    check("in_ready1", rdy1, e_n & ~md);
    model_step(e_n, md, v, code);
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_out0"}, out0, 0);
    check({tag, "_idx0"}, idx0, 0);
    check({tag, "_wrap0"}, wr0, 0);
    check({tag, "_valid0"}, ov0, 0);
    check({tag, "_out1"}, out1, 0);
    check({tag, "_idx1"}, idx1, 0);
    check({tag, "_wrap1"}, wr1, 0);
    check({tag, "_valid1"}, ov1, 0);
  endtask

  // Asynchronous reset asserted and released between clock edges.
  task automatic reset_pulse();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    en       = 1'b0;
    in_valid = 1'b0;
    #1;
    rst_n = 1'b1;
    m_st[0] = 0;
    m_st[1] = 0;
    model_step(1'b0, 1'b0, 1'b0, 0);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      check("out0", out0, e.out);
      check("idx0", idx0, e.idx);
      check("wrap0", wr0, e.wrap);
      check("valid0", ov0, e.vld);
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      check("out1", out1, e.out);
      check("idx1", idx1, e.idx);
      check("wrap1", wr1, e.wrap);
      check("valid1", ov1, e.vld);
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish within time budget");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "timeout");
  end

  initial begin : stim
    bit r_en;
    bit r_md;
    m_st   = '{0, 0};
    m_code = '{0, 0};
    m_t    = '{0, 0};
    #2;
    check_zero("reset");
    check("reset_in_ready0", rdy0, 0);
    check("reset_in_ready1", rdy1, 0);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Direct back-to-back codes, then hold.
    step(1, 0, 1, 5);
    step(1, 0, 1, 0);
    step(1, 0, 1, 7);
    step(1, 0, 0, 0);
    step(1, 0, 0, 3);

    // Disable while a code is offered: ignored, goes idle.
    step(0, 0, 1, 3);
    step(0, 1, 1, 2);

    // Full scan period plus a bit (covers both wraps and DWELL=1 sequence).
    for (int i = 0; i < 40; i++) step(1, 1, 0, 0);

    // Leave scan, re-enter, switch to direct with a code mid-dwell at idx 3.
    step(0, 0, 0, 0);
    for (int i = 0; i < 14; i++) step(1, 1, 0, 0);
    step(1, 0, 1, 6);
    step(1, 0, 0, 0);

    // DIRECT -> SCAN on mode rise, then mode drop without a code.
    for (int i = 0; i < 6; i++) step(1, 1, 1, 4);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);

    // Reset mid-scan, then restart scan.
    for (int i = 0; i < 10; i++) step(1, 1, 0, 0);
    reset_pulse();
    for (int i = 0; i < 6; i++) step(1, 1, 0, 0);

    // Randomized traffic with sticky mode so scans run long enough to advance.
    r_md = 1'b0;
    for (int i = 0; i < 600; i++) begin
      r_en = ($urandom_range(0, 11) != 0);
      if ($urandom_range(0, 15) == 0) r_md = ~r_md;
      step(r_en, r_md, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
    end

    @(negedge clk);
    #1;
    check("scoreboard_drained", q0.size() + q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
